// File: rtl/alu_pkg.sv
// Shared ALU writeback definitions: op-code encodings and datapath widths.
package alu_pkg;

  localparam int ALU_OP_W = 3;
  localparam int DATA_W   = 16;
  localparam int RESULT_W = 32;

  localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_MUL  = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_DIV  = 3'b101;
  localparam logic [ALU_OP_W-1:0] OP_MFHI = 3'b110;
  localparam logic [ALU_OP_W-1:0] OP_MFLO = 3'b111;

  // MUL/DIV only update HI/LO and never request a register-file write.
  function automatic logic is_hilo_write(input logic [ALU_OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO, registered storage; push visible at head one cycle later.
// Push ignored when full (even if popping), pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/alu_writeback.sv
// Queues ALU results and retires them in order to the register file or HI/LO.
// Min 1 cycle accept-to-wb_valid; in_ready drops when the queue is full, wb stalls hold the head.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [RESULT_W-1:0] in_result,
  input  logic [DEST_W-1:0]   in_dest,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [DEST_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [RESULT_W-1:0] result;
    logic [DEST_W-1:0]   dest;
  } entry_t;

  entry_t             in_entry, head;
  logic               fifo_full, fifo_empty, push, pop, head_hilo;
  logic [CNT_W-1:0]   fifo_count;
  logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;

  assign in_entry = '{op: in_op, result: in_result, dest: in_dest};
  assign in_ready = !fifo_full && !reset;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (in_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign head_hilo = is_hilo_write(head.op);
  assign pop       = !fifo_empty && (head_hilo || wb_ready);

  always_comb begin
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    if (!fifo_empty && !head_hilo) begin
      wb_valid = 1'b1;
      wb_addr  = head.dest;
      unique case (head.op)
        OP_MFHI: wb_data = hi_q;
        OP_MFLO: wb_data = lo_q;
        default: wb_data = head.result[DATA_W-1:0];
      endcase
    end
  end

  // MUL and DIV share the packing: upper half to HI, lower half to LO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (pop && head_hilo) begin
      hi_d = head.result[RESULT_W-1:DATA_W];
      lo_d = head.result[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  occupancy_bound : assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CNT_W'(DEPTH));

endmodule
